// File: rtl/shift_reg_seq_pkg.sv
// rtl/shift_reg_seq_pkg.sv - shared types for the shift register sequencer
//
// Purpose:
//   Operation encodings and sequencer state type shared by the top level,
//   the single-step shifter and the register interface.
// Contents:
//   op_e    : OP_SHL, OP_SHR, OP_SAR, OP_ROL (2-bit op field encoding)
//   state_e : ST_IDLE, ST_SHIFT

package shift_pkg;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,  // shift left, serial_in fills bit 0
    OP_SHR = 2'b01,  // shift right, serial_in fills the MSB
    OP_SAR = 2'b10,  // arithmetic shift right, MSB replicated
    OP_ROL = 2'b11   // rotate left, MSB wraps into bit 0
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : shift_pkg

// File: rtl/shift_reg_seq_if.sv
// rtl/shift_reg_seq_if.sv - control/data bundle for the shift register sequencer
//
// Purpose:
//   Groups the command inputs and status outputs of shift_reg_seq.
// Signals:
//   clear      : synchronous clear, aborts any running sequence
//   load       : capture load_data (idle only)
//   load_data  : WIDTH-bit parallel load value
//   start      : begin a shift sequence (idle only)
//   op         : 2-bit operation, see shift_pkg::op_e
//   amount     : CNT_W-bit shift count, saturates at WIDTH
//   serial_in  : fill bit for SHL/SHR, latched at start
//   q          : register contents
//   busy       : high while a sequence is in progress
//   done       : one-cycle pulse at sequence end
//   carry_out  : last bit shifted out
//   zero       : q == 0
// Modports:
//   master : drives commands, observes status
//   slave  : the sequencer itself

interface shift_reg_seq_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             carry_out;
  logic             zero;

  modport master (
    output clear, load, load_data, start, op, amount, serial_in,
    input  q, busy, done, carry_out, zero
  );

  modport slave (
    input  clear, load, load_data, start, op, amount, serial_in,
    output q, busy, done, carry_out, zero
  );

endinterface : shift_reg_seq_if

// File: rtl/shift_reg_seq_shift_step.sv
// rtl/shift_reg_seq_shift_step.sv - combinational one-position shifter
//
// Purpose:
//   Computes the register value after a single shift/rotate step and the bit
//   that leaves the register on that step.
// Ports:
//   i_q         : current register value (WIDTH)
//   i_op        : operation (shift_pkg::op_e)
//   i_serial_in : fill bit for SHL/SHR
//   o_q         : register value after one step (WIDTH)
//   o_bit       : bit shifted out (MSB for SHL/ROL, LSB for SHR/SAR)

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  op_e              i_op,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_q,
  output logic             o_bit
);

  always_comb begin
    o_q   = i_q;
    o_bit = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_q   = {i_q[WIDTH-2:0], i_serial_in};
        o_bit = i_q[WIDTH-1];
      end
      OP_SHR: begin
        o_q   = {i_serial_in, i_q[WIDTH-1:1]};
        o_bit = i_q[0];
      end
      OP_SAR: begin
        o_q   = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_bit = i_q[0];
      end
      OP_ROL: begin
        o_q   = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_bit = i_q[WIDTH-1];
      end
      default: begin
        o_q   = i_q;
        o_bit = 1'b0;
      end
    endcase
  end

endmodule : shift_step

// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - parametrised shift register with N-step sequencer
//
// Purpose:
//   Parallel-loads a WIDTH-bit value, then shifts or rotates it by a
//   requested number of positions, one position per clock, reporting
//   busy/done, the last bit shifted out and a zero flag.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : shift_reg_seq_if.slave (commands in, status out)

module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           resetn,
  shift_reg_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  op_e              r_op;
  logic             r_serial;
  logic             r_busy;
  logic             r_done;
  logic             r_carry;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  op_e              w_op_nxt;
  logic             w_serial_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_carry_nxt;

  logic [CNT_W-1:0] w_eff_amt;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_bit;

  // Amounts above WIDTH behave as a full-width shift.
  assign w_eff_amt = (bus.amount > MAX_AMT) ? MAX_AMT : bus.amount;

  // The step shifter always works from the latched op/fill bit, so changes
  // on the live inputs during a sequence have no effect.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_q         (r_q),
    .i_op        (r_op),
    .i_serial_in (r_serial),
    .o_q         (w_step_q),
    .o_bit       (w_step_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_cnt    <= '0;
      r_op     <= OP_SHL;
      r_serial <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_serial <= w_serial_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_carry  <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_serial_nxt = r_serial;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;   // done is a single-cycle pulse
    w_carry_nxt  = r_carry;

    case (r_state)
      ST_IDLE: begin
        if (bus.clear) begin
          w_q_nxt     = '0;
          w_carry_nxt = 1'b0;
        end else if (bus.load) begin
          w_q_nxt     = bus.load_data;
          w_carry_nxt = 1'b0;
        end else if (bus.start) begin
          w_op_nxt     = op_e'(bus.op);
          w_serial_nxt = bus.serial_in;
          if (w_eff_amt == '0) begin
            // Nothing to shift: complete immediately without going busy.
            w_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = w_eff_amt;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (bus.clear) begin
          // Abort: no done pulse for a cancelled sequence.
          w_q_nxt     = '0;
          w_carry_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_q_nxt     = w_step_q;
          w_carry_nxt = w_step_bit;
          w_cnt_nxt   = r_cnt - ONE;
          if (r_cnt == ONE) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.q         = r_q;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.carry_out = r_carry;
  assign bus.zero      = (r_q == '0);

endmodule : shift_reg_seq

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - self-checking bench for shift_reg_seq

module tb_shift_reg_seq;

  logic clk = 1'b0;
  logic resetn;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  shift_reg_seq_if #(.WIDTH(8)) bus ();

  shift_reg_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one shift step on an 8-bit value using plain arithmetic.
  function automatic int ref_next(input int x, input int opv, input int s);
    case (opv)
      0:       return ((x * 2) % 256) + s;
      1:       return (x / 2) + (s * 128);
      2:       return (x / 2) + ((x >= 128) ? 128 : 0);
      default: return ((x * 2) % 256) + ((x >= 128) ? 1 : 0);
    endcase
  endfunction

  function automatic int ref_out(input int x, input int opv);
    if (opv == 0 || opv == 3) return (x >= 128) ? 1 : 0;
    return x % 2;
  endfunction

  task automatic do_load(input logic [7:0] v);
    bus.load      = 1'b1;
    bus.load_data = v;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    int exp_q [$];
    int exp_c [$];
    resetn        = 1'b1;
    bus.clear     = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.amount    = '0;
    bus.serial_in = 1'b0;

    // Reset asserted mid-cycle takes effect immediately.
    #2 resetn = 1'b0;
    #1;
    chk("rst_q", bus.q, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_carry", bus.carry_out, 1'b0);
    chk("rst_zero", bus.zero, 1'b1);
    tick();
    resetn = 1'b1;
    tick();

    // SHL 0xB5 by 3, fill 0.
    do_load(8'hB5);
    chk("shl_load", bus.q, 8'hB5);
    bus.start = 1'b1; bus.op = 2'b00; bus.amount = 4'd3; bus.serial_in = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("shl_busy0", bus.busy, 1'b1);
    chk("shl_q0", bus.q, 8'hB5);
    tick();
    chk("shl_q1", bus.q, 8'h6A); chk("shl_c1", bus.carry_out, 1'b1); chk("shl_b1", bus.busy, 1'b1);
    tick();
    chk("shl_q2", bus.q, 8'hD4); chk("shl_c2", bus.carry_out, 1'b0); chk("shl_b2", bus.busy, 1'b1);
    chk("shl_d2", bus.done, 1'b0);
    tick();
    chk("shl_q3", bus.q, 8'hA8); chk("shl_c3", bus.carry_out, 1'b1);
    chk("shl_b3", bus.busy, 1'b0); chk("shl_d3", bus.done, 1'b1);
    tick();
    chk("shl_d4", bus.done, 1'b0);

    // SAR 0x96 by 2.
    do_load(8'h96);
    bus.start = 1'b1; bus.op = 2'b10; bus.amount = 4'd2;
    tick();
    bus.start = 1'b0;
    tick();
    chk("sar_q1", bus.q, 8'hCB); chk("sar_d1", bus.done, 1'b0);
    tick();
    chk("sar_q2", bus.q, 8'hE5); chk("sar_c2", bus.carry_out, 1'b1); chk("sar_d2", bus.done, 1'b1);
    tick();
    chk("sar_d3", bus.done, 1'b0);

    // ROL 0x81 by 9 saturates to 8 shifts.
    do_load(8'h81);
    bus.start = 1'b1; bus.op = 2'b11; bus.amount = 4'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rol_busy%0d", i), bus.busy, 1'b1);
      tick();
    end
    chk("rol_q", bus.q, 8'h81); chk("rol_c", bus.carry_out, 1'b1);
    chk("rol_busy_end", bus.busy, 1'b0); chk("rol_done", bus.done, 1'b1);
    tick();

    // SHR with mid-sequence start/load ignored, then clear aborts.
    do_load(8'hF0);
    bus.start = 1'b1; bus.op = 2'b01; bus.amount = 4'd4; bus.serial_in = 1'b1;
    tick();
    bus.load = 1'b1; bus.load_data = 8'h12; bus.op = 2'b00; bus.serial_in = 1'b0;
    tick();
    bus.start = 1'b0; bus.load = 1'b0;
    chk("abt_q1", bus.q, 8'hF8); chk("abt_b1", bus.busy, 1'b1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("abt_q", bus.q, 8'h00); chk("abt_busy", bus.busy, 1'b0);
    chk("abt_done", bus.done, 1'b0); chk("abt_carry", bus.carry_out, 1'b0);
    chk("abt_zero", bus.zero, 1'b1);
    tick();
    chk("abt_done2", bus.done, 1'b0); chk("abt_q2", bus.q, 8'h00);

    // Zero amount, then back-to-back start on the done cycle.
    do_load(8'h3C);
    bus.start = 1'b1; bus.op = 2'b00; bus.amount = 4'd0; bus.serial_in = 1'b0;
    tick();
    chk("z_done", bus.done, 1'b1); chk("z_busy", bus.busy, 1'b0); chk("z_q", bus.q, 8'h3C);
    bus.amount = 4'd1;
    tick();
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1'b1); chk("b2b_done0", bus.done, 1'b0);
    tick();
    chk("b2b_q", bus.q, 8'h78); chk("b2b_done", bus.done, 1'b1); chk("b2b_c", bus.carry_out, 1'b0);
    tick();

    // Randomized sequences against the arithmetic reference.
    for (int it = 0; it < 40; it++) begin
      int v, opv, amt, s, eff, x;
      v   = int'($urandom_range(0, 255));
      opv = int'($urandom_range(0, 3));
      amt = int'($urandom_range(0, 12));
      s   = int'($urandom_range(0, 1));
      eff = (amt > 8) ? 8 : amt;
      exp_q.delete();
      exp_c.delete();
      x = v;
      for (int k = 0; k < eff; k++) begin
        exp_c.push_back(ref_out(x, opv));
        x = ref_next(x, opv, s);
        exp_q.push_back(x);
      end
      do_load(v[7:0]);
      bus.start = 1'b1; bus.op = opv[1:0]; bus.amount = amt[3:0]; bus.serial_in = s[0];
      tick();
      bus.start = 1'b0;
      bus.serial_in = ~s[0];
      if (eff == 0) begin
        chk("rnd_z_done", bus.done, 1'b1);
        chk("rnd_z_q", bus.q, v);
      end else begin
        chk("rnd_busy_start", bus.busy, 1'b1);
        for (int k = 0; k < eff; k++) begin
          tick();
          chk($sformatf("rnd%0d_q%0d", it, k), bus.q, exp_q[k]);
          chk($sformatf("rnd%0d_c%0d", it, k), bus.carry_out, exp_c[k]);
          chk($sformatf("rnd%0d_b%0d", it, k), bus.busy, (k == eff - 1) ? 0 : 1);
          chk($sformatf("rnd%0d_d%0d", it, k), bus.done, (k == eff - 1) ? 1 : 0);
        end
        chk("rnd_zero", bus.zero, (exp_q[eff-1] == 0) ? 1 : 0);
      end
      tick();
    end

    // Async reset in the middle of a sequence.
    do_load(8'h5A);
    bus.start = 1'b1; bus.op = 2'b00; bus.amount = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("ar_q", bus.q, 8'h00); chk("ar_busy", bus.busy, 1'b0); chk("ar_carry", bus.carry_out, 1'b0);
    tick();
    chk("ar_done", bus.done, 1'b0);
    resetn = 1'b1;
    tick();
    chk("ar_idle_busy", bus.busy, 1'b0); chk("ar_idle_done", bus.done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_shift_reg_seq
